// File: rtl/series_pkg.sv
// Shared types and constants for the series-evaluation controller.
package series_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ACC,
    ST_MUL_X,
    ST_MUL_L,
    ST_CHECK,
    ST_DONE
  } series_state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic SEL_X_IN  = 1'b0;
  localparam logic SEL_T_ONE = 1'b0;
  localparam logic SEL_T_MUL = 1'b1;

endpackage

// File: rtl/series_ctrl_term_counter.sv
// Term counter: CNT_W-bit up counter with sync clear/enable and a
// terminal-count flag at N_TERMS-1.
module term_counter #(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CNT_W'(N_TERMS - 1));

endmodule

// File: rtl/series_ctrl.sv
// Series-evaluation control unit: sequences ACC/MUL_X/MUL_L/CHECK per term
// and stops at N_TERMS or when the datapath reports the sum reached the bound.
module series_ctrl
  import series_pkg::*;
#(
  parameter int unsigned N_TERMS  = 8,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned ALT_SIGN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt,
  output logic             busy,
  output logic             done,
  output logic             hit_bound,
  output logic             sum_clr,
  output logic             counter_en,
  output logic             sel_1,
  output logic             sel_2,
  output logic             sel_x,
  output logic             sel_t,
  output logic             load_x,
  output logic             load_m,
  output logic             load_t,
  output logic             mode,
  output logic [CNT_W-1:0] lut_addr
);

  series_state_t    state_q;
  series_state_t    state_d;
  logic             hit_bound_q;
  logic             hit_bound_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;
  logic [CNT_W-1:0] count;

  term_counter #(
    .CNT_W   (CNT_W),
    .N_TERMS (N_TERMS)
  ) u_term_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_inc),
    .count_o (count),
    .tc_o    (cnt_tc)
  );

  // Next-state; the gt=0 exit outranks the terminal-count exit.
  always_comb begin
    state_d     = state_q;
    hit_bound_d = hit_bound_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        hit_bound_d = 1'b0;
        cnt_clr     = 1'b1;
        state_d     = ST_ACC;
      end
      ST_ACC:   state_d = ST_MUL_X;
      ST_MUL_X: state_d = ST_MUL_L;
      ST_MUL_L: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!gt) begin
          hit_bound_d = 1'b1;
          state_d     = ST_DONE;
        end else if (cnt_tc) begin
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hit_bound_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_bound_q <= hit_bound_d;
    end
  end

  // Moore strobe decode from the registered state and count.
  always_comb begin
    sum_clr    = 1'b0;
    counter_en = 1'b0;
    sel_1      = 1'b0;
    sel_2      = 1'b0;
    sel_x      = 1'b0;
    sel_t      = 1'b0;
    load_x     = 1'b0;
    load_m     = 1'b0;
    load_t     = 1'b0;
    mode       = MODE_ADD;
    done       = 1'b0;
    case (state_q)
      ST_INIT: begin
        sel_x   = SEL_X_IN;
        load_x  = 1'b1;
        sel_t   = SEL_T_ONE;
        load_t  = 1'b1;
        sum_clr = 1'b1;
      end
      ST_ACC: begin
        load_m = 1'b1;
        mode   = ((ALT_SIGN != 0) && count[0]) ? MODE_SUB : MODE_ADD;
      end
      ST_MUL_X: begin
        sel_t  = SEL_T_MUL;
        load_t = 1'b1;
      end
      ST_MUL_L: begin
        sel_2  = 1'b1;
        sel_t  = SEL_T_MUL;
        load_t = 1'b1;
      end
      ST_CHECK: counter_en = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign hit_bound = hit_bound_q;
  assign lut_addr  = count;

endmodule

// File: tb/tb_series_ctrl.sv
// Self-checking bench for series_ctrl: per-cycle model compare on two
// configurations plus directed timing checks with literal expectations.
module tb_series_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, gt = 1'b1, start2 = 1'b0, gt2 = 1'b1;

  logic busy, done, hit_bound, sum_clr, counter_en, sel_1, sel_2, sel_x, sel_t;
  logic load_x, load_m, load_t, mode;
  logic [2:0] lut_addr;
  logic busy2, done2, hit_bound2, sum_clr2, counter_en2, sel_12, sel_22, sel_x2, sel_t2;
  logic load_x2, load_m2, load_t2, mode2;
  logic [0:0] lut_addr2;

  always #5 clk = ~clk;

  series_ctrl #(.N_TERMS(8), .CNT_W(3), .ALT_SIGN(1)) dut8 (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .busy(busy), .done(done),
    .hit_bound(hit_bound), .sum_clr(sum_clr), .counter_en(counter_en),
    .sel_1(sel_1), .sel_2(sel_2), .sel_x(sel_x), .sel_t(sel_t),
    .load_x(load_x), .load_m(load_m), .load_t(load_t), .mode(mode),
    .lut_addr(lut_addr)
  );

  series_ctrl #(.N_TERMS(2), .CNT_W(1), .ALT_SIGN(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gt(gt2), .busy(busy2), .done(done2),
    .hit_bound(hit_bound2), .sum_clr(sum_clr2), .counter_en(counter_en2),
    .sel_1(sel_12), .sel_2(sel_22), .sel_x(sel_x2), .sel_t(sel_t2),
    .load_x(load_x2), .load_m(load_m2), .load_t(load_t2), .mode(mode2),
    .lut_addr(lut_addr2)
  );

  // Output vector: {busy,done,hit,sum_clr,cen,sel_1,sel_2,sel_x,sel_t,load_x,load_m,load_t,mode,lut[2:0]}
  logic [15:0] v8, v2;
  assign v8 = {busy, done, hit_bound, sum_clr, counter_en, sel_1, sel_2, sel_x, sel_t,
               load_x, load_m, load_t, mode, lut_addr};
  assign v2 = {busy2, done2, hit_bound2, sum_clr2, counter_en2, sel_12, sel_22, sel_x2, sel_t2,
               load_x2, load_m2, load_t2, mode2, 2'b00, lut_addr2};

  int ncomp = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Run model: pos counts cycles since INIT; a run ends at end_pos (the DONE cycle).
  typedef struct packed {
    bit active;
    int pos;
    int end_pos;
    int k;
    bit hb;
  } mdl_t;

  mdl_t m8, m2;

  function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit st, input bit g, input int n);
    mdl_t x;
    x = m;
    if (r) begin
      x.active = 1'b0; x.pos = 0; x.end_pos = -1; x.k = 0; x.hb = 1'b0;
      return x;
    end
    if (!x.active) begin
      if (st) begin
        x.active = 1'b1; x.pos = 0; x.end_pos = -1;
      end
      return x;
    end
    if (x.pos == x.end_pos) begin
      x.active = 1'b0;
      return x;
    end
    if (x.pos == 0) begin
      x.hb = 1'b0; x.k = 0;
    end else if ((x.pos - 1) % 4 == 3) begin
      if (!g) begin
        x.hb = 1'b1; x.end_pos = x.pos + 1;
      end else if (x.k == n - 1) begin
        x.end_pos = x.pos + 1;
      end else begin
        x.k = x.k + 1;
      end
    end
    x.pos = x.pos + 1;
    return x;
  endfunction

  function automatic logic [15:0] exp_out(input mdl_t m, input bit alt);
    logic b, d, sc, ce, s2, st, lx, lm, lt, md;
    b = 0; d = 0; sc = 0; ce = 0; s2 = 0; st = 0; lx = 0; lm = 0; lt = 0; md = 0;
    if (m.active) begin
      b = 1;
      if (m.pos == 0) begin
        sc = 1; lx = 1; lt = 1;
      end else if (m.pos == m.end_pos) begin
        d = 1;
      end else begin
        case ((m.pos - 1) % 4)
          0: begin lm = 1; md = alt && (m.k % 2 == 1); end
          1: begin st = 1; lt = 1; end
          2: begin s2 = 1; st = 1; lt = 1; end
          default: ce = 1;
        endcase
      end
    end
    return {b, d, m.hb, sc, ce, 1'b0, s2, 1'b0, st, lx, lm, lt, md, 3'(m.k)};
  endfunction

  always @(posedge clk) begin
    m8 <= mdl_step(m8, rst, start, gt, 8);
    m2 <= mdl_step(m2, rst, start2, gt2, 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut8_outputs", 32'(v8), 32'(exp_out(m8, 1'b1)));
      check("dut2_outputs", 32'(v2), 32'(exp_out(m2, 1'b0)));
    end
  end

  logic [15:0] hist [0:127];

  // One window of len cycles; cycle c is observed at posedge+1 before its inputs are applied.
  task automatic run_win(input bit which, input int len, input int st0, input int st1, input int st2,
                         input bit hold, input int gt_low, input int rst_at,
                         output int done_c, output int nd);
    logic [15:0] v;
    done_c = -1;
    nd = 0;
    for (int c = 0; c < len; c++) begin
      v = which ? v2 : v8;
      if (c < 128) hist[c] = v;
      if (v[14]) begin
        nd++;
        if (done_c < 0) done_c = c;
      end
      rst = (c == rst_at);
      if (which) begin
        start2 = hold || (c == st0) || (c == st1) || (c == st2);
        gt2    = (c != gt_low);
        start  = 1'b0; gt = 1'b1;
      end else begin
        start  = hold || (c == st0) || (c == st1) || (c == st2);
        gt     = (c != gt_low);
        start2 = 1'b0; gt2 = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; gt = 1'b1; start2 = 1'b0; gt2 = 1'b1; rst = 1'b0;
  endtask

  int dc, nd, nacc, ncen, first_init;
  logic [7:0] modes;
  logic [31:0] luts;

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;

    // Idle after reset.
    run_win(0, 10, -1, -1, -1, 0, -1, -1, dc, nd);
    check("idle_outputs_zero", 32'(v8), 32'h0);
    check("idle_dut2_zero", 32'(v2), 32'h0);

    // Full run with alternating sign.
    run_win(0, 40, 0, -1, -1, 0, -1, -1, dc, nd);
    check("busy_cycle1", 32'(hist[1][15]), 32'd1);
    check("done_cycle_full", 32'(dc), 32'd34);
    check("done_count_full", 32'(nd), 32'd1);
    check("hit_bound_full", 32'(hist[34][13]), 32'd0);
    nacc = 0; ncen = 0; modes = '0; luts = '0;
    for (int c = 0; c < 40; c++) begin
      if (hist[c][5] && nacc < 8) begin
        modes[nacc] = hist[c][3];
        luts = luts | (32'(hist[c][2:0]) << (3 * nacc));
        nacc++;
      end
      if (hist[c][11]) ncen++;
    end
    check("acc_mode_seq", 32'(modes), 32'hAA);
    check("acc_lut_seq", luts, 32'(24'o76543210));
    check("check_cycles", 32'(ncen), 32'd8);

    // Early exit at k=2.
    run_win(0, 20, 0, -1, -1, 0, 13, -1, dc, nd);
    check("done_cycle_early", 32'(dc), 32'd14);
    check("hit_bound_early", 32'(hist[14][13]), 32'd1);
    check("done_count_early", 32'(nd), 32'd1);

    // Next run clears hit_bound.
    run_win(0, 40, 0, -1, -1, 0, -1, -1, dc, nd);
    check("hit_bound_cleared", 32'(hist[2][13]), 32'd0);
    check("done_cycle_rerun", 32'(dc), 32'd34);

    // Start pulses while busy are ignored.
    run_win(0, 45, 0, 5, 20, 0, -1, -1, dc, nd);
    check("done_count_ignored", 32'(nd), 32'd1);
    check("done_cycle_ignored", 32'(dc), 32'd34);

    // Start held high: back-to-back runs.
    run_win(0, 75, -1, -1, -1, 1, -1, -1, dc, nd);
    first_init = -1;
    for (int c = 35; c < 75; c++) begin
      if (hist[c][12] && first_init < 0) first_init = c;
    end
    check("done_cycle_hold", 32'(dc), 32'd34);
    check("second_init_cycle", 32'(first_init), 32'd36);
    check("done_count_hold", 32'(nd), 32'd2);
    run_win(0, 40, -1, -1, -1, 0, -1, -1, dc, nd);

    // Reset mid-run, then a fresh start.
    run_win(0, 60, 0, 20, -1, 0, -1, 17, dc, nd);
    check("after_rst_zero", 32'(hist[18]), 32'h0);
    check("done_count_rst", 32'(nd), 32'd1);
    check("done_cycle_after_rst", 32'(dc), 32'd54);

    // N_TERMS=2: gt=0 on the terminal term.
    run_win(1, 15, 0, -1, -1, 0, 9, -1, dc, nd);
    check("n2_done_cycle_prio", 32'(dc), 32'd10);
    check("n2_hit_bound_prio", 32'(hist[10][13]), 32'd1);
    // N_TERMS=2: gt=0 on the first term.
    run_win(1, 15, 0, -1, -1, 0, 5, -1, dc, nd);
    check("n2_done_cycle_first", 32'(dc), 32'd6);
    check("n2_hit_bound_first", 32'(hist[6][13]), 32'd1);
    // N_TERMS=2: full run.
    run_win(1, 15, 0, -1, -1, 0, -1, -1, dc, nd);
    check("n2_done_cycle_full", 32'(dc), 32'd10);
    check("n2_hit_bound_full", 32'(hist[10][13]), 32'd0);
    check("n2_lut_last_check", 32'(hist[9][2:0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
